// File: rtl/condicionador_sensores_if.sv
// -----------------------------------------------------------------------------
// condicionador_sensores_if
// Purpose : bundles the sensor-side signals of the conditioner: the six raw
//           probe/threshold inputs and the conditioned outputs returned to the
//           irrigation controller.
// Signals :
//   H_raw, M_raw, L_raw    raw tank level probes (high, medium, low)
//   Us_raw, Ua_raw, T_raw  raw soil-moisture, air-humidity, temperature flags
//   H, M, L, Us, Ua, T     debounced versions of the raw inputs
//   Pronto                 conditioned outputs are qualified
//   ErroNivel              persistent level-probe inconsistency
//   Mudou                  one-cycle pulse after any conditioned output changes
// Modports:
//   master  side that drives the raw inputs and consumes the conditioned outputs
//   slave   the conditioner itself
// -----------------------------------------------------------------------------
interface condicionador_sensores_if;
    logic H_raw;
    logic M_raw;
    logic L_raw;
    logic Us_raw;
    logic Ua_raw;
    logic T_raw;
    logic H;
    logic M;
    logic L;
    logic Us;
    logic Ua;
    logic T;
    logic Pronto;
    logic ErroNivel;
    logic Mudou;

    modport master (
        output H_raw, M_raw, L_raw, Us_raw, Ua_raw, T_raw,
        input  H, M, L, Us, Ua, T, Pronto, ErroNivel, Mudou
    );

    modport slave (
        input  H_raw, M_raw, L_raw, Us_raw, Ua_raw, T_raw,
        output H, M, L, Us, Ua, T, Pronto, ErroNivel, Mudou
    );
endinterface

// File: rtl/condicionador_sensores.sv
// -----------------------------------------------------------------------------
// condicionador_sensores
// Purpose : conditions six asynchronous sensor inputs for an irrigation
//           controller. Each input is synchronized (two flops) and debounced;
//           a startup machine qualifies the outputs once the filters have had
//           time to settle; an error machine flags a persistent inconsistency
//           between the tank level probes; a change pulse reports any update.
// Parameters:
//   DEB_CYCLES  consecutive disagreeing cycles before a filtered output flips (2..255)
//   ERR_CYCLES  persistence needed to enter and to leave the error condition (1..255)
// Ports:
//   CLK                        clock, rising edge
//   RST                        synchronous reset, active high
//   H_raw, M_raw, L_raw        raw level probes (async)
//   Us_raw, Ua_raw, T_raw      raw threshold flags (async)
//   H, M, L, Us, Ua, T         filtered outputs (registered)
//   Pronto                     filtered outputs qualified (registered)
//   ErroNivel                  level inconsistency, states ERR/REC (registered)
//   Mudou                      one-cycle pulse the cycle after a filtered change
// -----------------------------------------------------------------------------
module condicionador_sensores #(
    parameter int DEB_CYCLES = 16,
    parameter int ERR_CYCLES = 8
) (
    input  logic CLK,
    input  logic RST,
    input  logic H_raw,
    input  logic M_raw,
    input  logic L_raw,
    input  logic Us_raw,
    input  logic Ua_raw,
    input  logic T_raw,
    output logic H,
    output logic M,
    output logic L,
    output logic Us,
    output logic Ua,
    output logic T,
    output logic Pronto,
    output logic ErroNivel,
    output logic Mudou
);

    localparam int         NCH       = 6;
    localparam logic [8:0] DEB_LIM   = 9'(DEB_CYCLES);
    // DEB_CYCLES+2 can reach 257, so the startup count is one bit wider.
    localparam logic [8:0] START_LIM = 9'(DEB_CYCLES + 2);
    localparam logic [8:0] ERR_LIM   = 9'(ERR_CYCLES);

    // Channel order: 0=H 1=M 2=L 3=Us 4=Ua 5=T
    logic [NCH-1:0] raw_vec;
    logic [NCH-1:0] filt_vec;

    assign raw_vec = {T_raw, Ua_raw, Us_raw, L_raw, M_raw, H_raw};

    // -------------------------------------------------------------------------
    // Per-channel synchronizer + debounce filter
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            logic       sync1_q;
            logic       sync2_q;
            logic       filt_q;
            logic       filt_d;
            logic [7:0] cnt_q;
            logic [7:0] cnt_d;
            logic [8:0] cnt_inc;

            always_comb begin
                cnt_inc = {1'b0, cnt_q} + 9'd1;
                filt_d  = filt_q;
                cnt_d   = cnt_q;
                if (sync2_q == filt_q) begin
                    cnt_d = '0;
                end else if (cnt_inc == DEB_LIM) begin
                    // The count would reach the limit: flip instead of storing it.
                    filt_d = ~filt_q;
                    cnt_d  = '0;
                end else if (cnt_q != 8'hFF) begin
                    cnt_d = cnt_inc[7:0];
                end
            end

            always_ff @(posedge CLK) begin
                if (RST) begin
                    sync1_q <= 1'b0;
                    sync2_q <= 1'b0;
                    filt_q  <= 1'b0;
                    cnt_q   <= '0;
                end else begin
                    sync1_q <= raw_vec[gi];
                    sync2_q <= sync1_q;
                    filt_q  <= filt_d;
                    cnt_q   <= cnt_d;
                end
            end

            assign filt_vec[gi] = filt_q;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Startup machine: Pronto rises DEB_CYCLES+2 cycles after reset release,
    // i.e. once a value present at release could have crossed the filters.
    // -------------------------------------------------------------------------
    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } start_t;

    start_t     start_q;
    logic [8:0] start_cnt_q;
    logic       pronto_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            start_q     <= ST_INIT;
            start_cnt_q <= '0;
            pronto_q    <= 1'b0;
        end else begin
            case (start_q)
                ST_INIT: begin
                    if (start_cnt_q + 9'd1 == START_LIM) begin
                        start_q     <= ST_RUN;
                        start_cnt_q <= START_LIM;
                        pronto_q    <= 1'b1;
                    end else begin
                        start_cnt_q <= start_cnt_q + 9'd1;
                        pronto_q    <= 1'b0;
                    end
                end
                ST_RUN: begin
                    pronto_q <= 1'b1;
                end
                default: begin
                    start_q  <= ST_INIT;
                    pronto_q <= 1'b0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Level-probe error machine
    // A probe above an inactive one (H without M, or M without L) is
    // physically impossible for a tank, so it points at a faulty probe.
    // -------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ER_OK   = 2'd0,
        ER_SUSP = 2'd1,
        ER_ERR  = 2'd2,
        ER_REC  = 2'd3
    } err_t;

    err_t       err_q;
    logic [7:0] err_cnt_q;
    logic [8:0] err_cnt_p2;
    logic       erro_q;
    logic       incons;
    logic       err_run_done;

    assign incons = (filt_vec[0] & ~filt_vec[1]) | (filt_vec[1] & ~filt_vec[2]);

    // The cycle that entered SUSP/REC already saw the condition once, so the
    // persistence run is complete when count+2 reaches ERR_CYCLES.
    assign err_cnt_p2   = {1'b0, err_cnt_q} + 9'd2;
    assign err_run_done = (err_cnt_p2 >= ERR_LIM);

    always_ff @(posedge CLK) begin
        if (RST || !pronto_q) begin
            err_q     <= ER_OK;
            err_cnt_q <= '0;
            erro_q    <= 1'b0;
        end else begin
            case (err_q)
                ER_OK: begin
                    erro_q    <= 1'b0;
                    err_cnt_q <= '0;
                    if (incons) begin
                        err_q <= ER_SUSP;
                    end
                end
                ER_SUSP: begin
                    if (!incons) begin
                        err_q     <= ER_OK;
                        err_cnt_q <= '0;
                        erro_q    <= 1'b0;
                    end else if (err_run_done) begin
                        err_q     <= ER_ERR;
                        err_cnt_q <= '0;
                        erro_q    <= 1'b1;
                    end else begin
                        err_cnt_q <= (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
                        erro_q    <= 1'b0;
                    end
                end
                ER_ERR: begin
                    erro_q    <= 1'b1;
                    err_cnt_q <= '0;
                    if (!incons) begin
                        err_q <= ER_REC;
                    end
                end
                ER_REC: begin
                    if (incons) begin
                        err_q     <= ER_ERR;
                        err_cnt_q <= '0;
                        erro_q    <= 1'b1;
                    end else if (err_run_done) begin
                        err_q     <= ER_OK;
                        err_cnt_q <= '0;
                        erro_q    <= 1'b0;
                    end else begin
                        err_cnt_q <= (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
                        erro_q    <= 1'b1;
                    end
                end
                default: begin
                    err_q     <= ER_OK;
                    err_cnt_q <= '0;
                    erro_q    <= 1'b0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Change pulse: compare the filtered outputs with their previous value, so
    // the pulse lands the cycle after the change and several simultaneous
    // channel flips merge into one pulse.
    // -------------------------------------------------------------------------
    logic [NCH-1:0] filt_dly_q;
    logic           mudou_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            filt_dly_q <= '0;
            mudou_q    <= 1'b0;
        end else begin
            filt_dly_q <= filt_vec;
            mudou_q    <= pronto_q & (|(filt_vec ^ filt_dly_q));
        end
    end

    assign H         = filt_vec[0];
    assign M         = filt_vec[1];
    assign L         = filt_vec[2];
    assign Us        = filt_vec[3];
    assign Ua        = filt_vec[4];
    assign T         = filt_vec[5];
    assign Pronto    = pronto_q;
    assign ErroNivel = erro_q;
    assign Mudou     = mudou_q;

endmodule

// File: tb/tb_condicionador_sensores.sv
// -----------------------------------------------------------------------------
// tb_condicionador_sensores
// Drives directed scenarios followed by random segments of raw-input levels.
// A window-based reference model predicts the outputs after every clock edge
// and queues them; a monitor pops and compares once per cycle.
// -----------------------------------------------------------------------------
module tb_condicionador_sensores;

    localparam int DEB    = 16;
    localparam int ERRC   = 8;
    localparam int ERR_TH = (ERRC < 2) ? 2 : ERRC;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    always #5 CLK = ~CLK;

    condicionador_sensores_if sif ();

    condicionador_sensores #(
        .DEB_CYCLES (DEB),
        .ERR_CYCLES (ERRC)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .H_raw     (sif.H_raw),
        .M_raw     (sif.M_raw),
        .L_raw     (sif.L_raw),
        .Us_raw    (sif.Us_raw),
        .Ua_raw    (sif.Ua_raw),
        .T_raw     (sif.T_raw),
        .H         (sif.H),
        .M         (sif.M),
        .L         (sif.L),
        .Us        (sif.Us),
        .Ua        (sif.Ua),
        .T         (sif.T),
        .Pronto    (sif.Pronto),
        .ErroNivel (sif.ErroNivel),
        .Mudou     (sif.Mudou)
    );

    // ---------------- scoreboard ----------------
    typedef struct {
        int         tgt;
        logic [8:0] v;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   edge_cnt = 0;
    bit   drv_done = 1'b0;

    always @(posedge CLK) edge_cnt <= edge_cnt + 1;

    // ---------------- reference model ----------------
    // Channel order 0=H 1=M 2=L 3=Us 4=Ua 5=T.
    // hist[ch][DEB] is the sample taken at the previous edge; hist[ch][0..DEB-1]
    // are the DEB samples before that. Because of the two-flop synchronizer a
    // filtered output flips at this edge exactly when those DEB samples all
    // disagree with it.
    bit m_hist [6][DEB+1];
    bit m_f    [6];
    int m_pc;
    bit m_pronto;
    bit m_errn;
    bit m_mudou;
    bit m_chg_prev;
    int m_run1;
    int m_run0;

    function automatic void model_step(input bit rst, input bit [5:0] raw);
        bit [5:0] tog;
        bit       inc;
        bit       pronto_old;
        if (rst) begin
            for (int c = 0; c < 6; c++) begin
                m_f[c] = 1'b0;
                for (int k = 0; k <= DEB; k++) m_hist[c][k] = 1'b0;
            end
            m_pc       = 0;
            m_pronto   = 1'b0;
            m_errn     = 1'b0;
            m_mudou    = 1'b0;
            m_chg_prev = 1'b0;
            m_run1     = 0;
            m_run0     = 0;
        end else begin
            pronto_old = m_pronto;
            inc = (m_f[0] && !m_f[1]) || (m_f[1] && !m_f[2]);
            if (!pronto_old) begin
                m_errn = 1'b0;
                m_run1 = 0;
                m_run0 = 0;
            end else begin
                if (inc) begin
                    m_run1++;
                    m_run0 = 0;
                end else begin
                    m_run0++;
                    m_run1 = 0;
                end
                if (!m_errn && m_run1 >= ERR_TH)     m_errn = 1'b1;
                else if (m_errn && m_run0 >= ERR_TH) m_errn = 1'b0;
            end
            m_mudou = pronto_old && m_chg_prev;
            for (int c = 0; c < 6; c++) begin
                tog[c] = 1'b1;
                for (int k = 0; k < DEB; k++)
                    if (m_hist[c][k] == m_f[c]) tog[c] = 1'b0;
                for (int k = 0; k < DEB; k++) m_hist[c][k] = m_hist[c][k+1];
                m_hist[c][DEB] = raw[c];
                m_f[c] = m_f[c] ^ tog[c];
            end
            m_chg_prev = |tog;
            if (m_pc < 1000) m_pc++;
            m_pronto = (m_pc >= DEB + 2);
        end
    endfunction

    // ---------------- driver ----------------
    task automatic drive(input bit rst, input bit [5:0] raw);
        exp_t e;
        @(posedge CLK);
        #1;
        RST        = rst;
        sif.H_raw  = raw[0];
        sif.M_raw  = raw[1];
        sif.L_raw  = raw[2];
        sif.Us_raw = raw[3];
        sif.Ua_raw = raw[4];
        sif.T_raw  = raw[5];
        model_step(rst, raw);
        e.tgt = edge_cnt + 1;
        e.v   = {m_f[0], m_f[1], m_f[2], m_f[3], m_f[4], m_f[5], m_pronto, m_errn, m_mudou};
        exp_q.push_back(e);
    endtask

    task automatic segment(input string tag, input bit rst, input bit [5:0] raw, input int n);
        $display("%0t seg %-12s rst=%0b raw(T,Ua,Us,L,M,H)=%b cycles=%0d", $time, tag, rst, raw, n);
        for (int i = 0; i < n; i++) drive(rst, raw);
    endtask

    initial begin
        bit [5:0] r;
        int       len;
        RST        = 1'b1;
        sif.H_raw  = 1'b0;
        sif.M_raw  = 1'b0;
        sif.L_raw  = 1'b0;
        sif.Us_raw = 1'b0;
        sif.Ua_raw = 1'b0;
        sif.T_raw  = 1'b0;
        // startup with all inputs low
        segment("reset",     1'b1, 6'b000000, 2);
        segment("idle",      1'b0, 6'b000000, 25);
        // L rises and settles
        segment("L_rise",    1'b0, 6'b000100, 25);
        // Us glitches shorter than the filter
        segment("Us_p10",    1'b0, 6'b001100, 10);
        segment("Us_gap",    1'b0, 6'b000100, 3);
        segment("Us_p1",     1'b0, 6'b001100, 1);
        segment("Us_gap",    1'b0, 6'b000100, 3);
        segment("Us_p15",    1'b0, 6'b001100, 15);
        segment("Us_low",    1'b0, 6'b000100, 20);
        // H without M: error entry then recovery
        segment("H_on",      1'b0, 6'b000101, 40);
        segment("H_off",     1'b0, 6'b000100, 40);
        // back to ERR, then a 4-cycle REC window: M rises, L falls 4 later
        segment("H_on2",     1'b0, 6'b000101, 40);
        segment("M_on",      1'b0, 6'b000111, 4);
        segment("L_off",     1'b0, 6'b000011, 40);
        // one-cycle reset while in ERR
        segment("rst_err",   1'b1, 6'b000011, 1);
        segment("after_rst", 1'b0, 6'b000011, 40);
        // random segments
        r = 6'b000011;
        for (int s = 0; s < 150; s++) begin
            for (int c = 0; c < 6; c++)
                if ($urandom_range(0, 3) == 0) r[c] = ~r[c];
            if ($urandom_range(0, 39) == 0) begin
                len = $urandom_range(1, 3);
                segment("rand_rst", 1'b1, r, len);
            end else begin
                len = $urandom_range(1, 30);
                segment("rand", 1'b0, r, len);
            end
        end
        segment("tail", 1'b0, r, 40);
        drv_done = 1'b1;
    end

    // ---------------- monitor ----------------
    initial begin
        exp_t       e;
        logic [8:0] got;
        forever begin
            @(posedge CLK);
            #3;
            while (exp_q.size() > 0 && exp_q[0].tgt <= edge_cnt) begin
                e   = exp_q.pop_front();
                got = {sif.H, sif.M, sif.L, sif.Us, sif.Ua, sif.T,
                       sif.Pronto, sif.ErroNivel, sif.Mudou};
                n_checks++;
                if (e.tgt != edge_cnt) begin
                    n_fail++;
                    $display("FAIL sched edge %0d: entry for edge %0d was not checked on time", edge_cnt, e.tgt);
                end else if (got !== e.v) begin
                    n_fail++;
                    $display("FAIL outputs edge %0d (H,M,L,Us,Ua,T,Pronto,ErroNivel,Mudou): got %b expected %b",
                             edge_cnt, got, e.v);
                end
            end
            if (drv_done && exp_q.size() == 0) break;
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // ---------------- watchdog ----------------
    initial begin
        #(2_000_000);
        $display("FAIL watchdog: simulation did not complete, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
